// File: rtl/bf_core.sv
// Multi-cycle Brainfuck interpreter core: fetches opcodes from a synchronous ROM, operates on
// cells in a synchronous RAM and emits bytes on a strobed stdout port.
module bf_core #(
    parameter int unsigned DATA_ADDR_WIDTH  = 16,
    parameter int unsigned DATA_VALUE_WIDTH = 32,
    parameter int unsigned PROG_ADDR_WIDTH  = 16,
    parameter int unsigned PROG_VALUE_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en,
    output logic [PROG_ADDR_WIDTH-1:0]  prog_addr,
    output logic                        prog_ren,
    input  logic [PROG_VALUE_WIDTH-1:0] prog_rval,
    output logic [DATA_ADDR_WIDTH-1:0]  data_addr,
    output logic                        data_ren,
    output logic                        data_wen,
    output logic [DATA_VALUE_WIDTH-1:0] data_wval,
    input  logic [DATA_VALUE_WIDTH-1:0] data_rval,
    output logic [7:0]                  stdout,
    output logic                        stdout_en
);

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StScanFetch,
        StScanDecode,
        StHalt
    } state_e;

    localparam logic [PROG_VALUE_WIDTH-1:0] OpInc   = PROG_VALUE_WIDTH'(8'h2B);
    localparam logic [PROG_VALUE_WIDTH-1:0] OpDec   = PROG_VALUE_WIDTH'(8'h2D);
    localparam logic [PROG_VALUE_WIDTH-1:0] OpRight = PROG_VALUE_WIDTH'(8'h3E);
    localparam logic [PROG_VALUE_WIDTH-1:0] OpLeft  = PROG_VALUE_WIDTH'(8'h3C);
    localparam logic [PROG_VALUE_WIDTH-1:0] OpOut   = PROG_VALUE_WIDTH'(8'h2E);
    localparam logic [PROG_VALUE_WIDTH-1:0] OpOpen  = PROG_VALUE_WIDTH'(8'h5B);
    localparam logic [PROG_VALUE_WIDTH-1:0] OpClose = PROG_VALUE_WIDTH'(8'h5D);
    localparam logic [PROG_VALUE_WIDTH-1:0] OpEnd   = PROG_VALUE_WIDTH'(8'h00);

    localparam logic [PROG_ADDR_WIDTH-1:0] PcOne = PROG_ADDR_WIDTH'(1);
    localparam logic [DATA_ADDR_WIDTH-1:0] DpOne = DATA_ADDR_WIDTH'(1);

    state_e                       state_q, state_d;
    logic [PROG_ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [DATA_ADDR_WIDTH-1:0]   dp_q, dp_d;
    logic [PROG_ADDR_WIDTH-1:0]   depth_q, depth_d;
    logic                         dir_back_q, dir_back_d;
    logic [7:0]                   stdout_q, stdout_d;
    logic                         stdout_en_q, stdout_en_d;

    logic                         prog_ren_c, data_ren_c, data_wen_c;
    logic [DATA_VALUE_WIDTH-1:0]  wval_c;
    logic [PROG_ADDR_WIDTH-1:0]   depth_nxt;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        dp_d        = dp_q;
        depth_d     = depth_q;
        dir_back_d  = dir_back_q;
        stdout_d    = stdout_q;
        stdout_en_d = 1'b0;
        prog_ren_c  = 1'b0;
        data_ren_c  = 1'b0;
        data_wen_c  = 1'b0;
        wval_c      = data_rval;
        depth_nxt   = depth_q;

        unique case (state_q)
            StFetch: begin
                prog_ren_c = 1'b1;
                data_ren_c = 1'b1;
                state_d    = StDecode;
            end

            StDecode: begin
                state_d = StFetch;
                pc_d    = pc_q + PcOne;
                case (prog_rval)
                    OpInc: begin
                        data_wen_c = 1'b1;
                        wval_c     = data_rval + DATA_VALUE_WIDTH'(1);
                    end
                    OpDec: begin
                        data_wen_c = 1'b1;
                        wval_c     = data_rval - DATA_VALUE_WIDTH'(1);
                    end
                    OpRight: dp_d = dp_q + DpOne;
                    OpLeft:  dp_d = dp_q - DpOne;
                    OpOut: begin
                        stdout_d    = data_rval[7:0];
                        stdout_en_d = 1'b1;
                    end
                    OpOpen: begin
                        if (data_rval == '0) begin
                            depth_d    = PcOne;
                            dir_back_d = 1'b0;
                            state_d    = StScanFetch;
                        end
                    end
                    OpClose: begin
                        if (data_rval != '0) begin
                            depth_d    = PcOne;
                            dir_back_d = 1'b1;
                            pc_d       = pc_q - PcOne;
                            state_d    = StScanFetch;
                        end
                    end
                    OpEnd: begin
                        pc_d    = pc_q;
                        state_d = StHalt;
                    end
                    default: ;
                endcase
            end

            StScanFetch: begin
                prog_ren_c = 1'b1;
                state_d    = StScanDecode;
            end

            StScanDecode: begin
                if (!dir_back_q) begin
                    if (prog_rval == OpEnd) begin
                        state_d = StHalt;
                    end else begin
                        if (prog_rval == OpOpen)  depth_nxt = depth_q + PcOne;
                        if (prog_rval == OpClose) depth_nxt = depth_q - PcOne;
                        depth_d = depth_nxt;
                        pc_d    = pc_q + PcOne;
                        state_d = (depth_nxt == '0) ? StFetch : StScanFetch;
                    end
                end else begin
                    if (prog_rval == OpClose) depth_nxt = depth_q + PcOne;
                    if (prog_rval == OpOpen)  depth_nxt = depth_q - PcOne;
                    depth_d = depth_nxt;
                    if (depth_nxt == '0) begin
                        // Resume on the instruction just after the matching '['.
                        pc_d    = pc_q + PcOne;
                        state_d = StFetch;
                    end else if (pc_q == '0) begin
                        state_d = StHalt;
                    end else begin
                        pc_d    = pc_q - PcOne;
                        state_d = StScanFetch;
                    end
                end
            end

            StHalt: ;

            default: state_d = StHalt;
        endcase
    end

    // Strobes are gated so a stall or a reset cycle never touches the memories.
    assign prog_ren  = prog_ren_c & en & ~reset;
    assign data_ren  = data_ren_c & en & ~reset;
    assign data_wen  = data_wen_c & en & ~reset;
    assign data_wval = wval_c;
    assign prog_addr = pc_q;
    assign data_addr = dp_q;
    assign stdout    = stdout_q;
    assign stdout_en = stdout_en_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StFetch;
            pc_q        <= '0;
            dp_q        <= '0;
            depth_q     <= '0;
            dir_back_q  <= 1'b0;
            stdout_q    <= 8'h00;
            stdout_en_q <= 1'b0;
        end else if (en) begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            dp_q        <= dp_d;
            depth_q     <= depth_d;
            dir_back_q  <= dir_back_d;
            stdout_q    <= stdout_d;
            stdout_en_q <= stdout_en_d;
        end
    end

endmodule

// File: tb/tb_bf_core.sv
// Directed bench for bf_core: behavioural ROM/RAM models, small programs with hand-computed
// outputs, plus stall and mid-program reset scenarios.
module tb_bf_core;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [15:0] prog_addr;
    logic        prog_ren;
    logic [7:0]  prog_rval;
    logic [15:0] data_addr;
    logic        data_ren;
    logic        data_wen;
    logic [31:0] data_wval;
    logic [31:0] data_rval;
    logic [7:0]  stdout;
    logic        stdout_en;

    always #5 clk = ~clk;

    bf_core dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .prog_addr (prog_addr),
        .prog_ren  (prog_ren),
        .prog_rval (prog_rval),
        .data_addr (data_addr),
        .data_ren  (data_ren),
        .data_wen  (data_wen),
        .data_wval (data_wval),
        .data_rval (data_rval),
        .stdout    (stdout),
        .stdout_en (stdout_en)
    );

    logic [7:0]  rom [0:255];
    logic [31:0] ram [0:65535];
    logic        ram_clr = 1'b0;

    always @(posedge clk) begin
        if (prog_ren) prog_rval <= (prog_addr < 16'd256) ? rom[prog_addr[7:0]] : 8'h00;
        if (ram_clr) begin
            for (int i = 0; i < 65536; i++) ram[i] <= 32'h0;
        end else begin
            if (data_wen) ram[data_addr] <= data_wval;
            if (data_ren) data_rval <= ram[data_addr];
        end
    end

    logic [7:0]  out_q [$];
    logic [15:0] wr_addr_q [$];
    logic [31:0] wr_val_q [$];
    int          strobe_cnt = 0;

    always @(negedge clk) begin
        if (data_wen) begin
            wr_addr_q.push_back(data_addr);
            wr_val_q.push_back(data_wval);
        end
        if (stdout_en && en && !reset) out_q.push_back(stdout);
        if (prog_ren || data_ren || data_wen || (stdout_en && en && !reset)) strobe_cnt++;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic start_prog(input string s);
        en      = 1'b1;
        reset   = 1'b1;
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        for (int i = 0; i < s.len(); i++) rom[i] = s[i];
        ram_clr = 1'b1;
        @(negedge clk);
        ram_clr = 1'b0;
        @(negedge clk);
        out_q.delete();
        wr_addr_q.delete();
        wr_val_q.delete();
        reset = 1'b0;
    endtask

    task automatic run_to_halt(input string tag);
        int idle = 0;
        int cyc  = 0;
        int s0;
        while (idle < 3 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (prog_ren || data_ren) idle = 0;
            else idle++;
        end
        check({tag, "_halted"}, 64'(idle >= 3), 64'd1);
        s0 = strobe_cnt;
        repeat (10) @(negedge clk);
        check({tag, "_halt_quiet"}, 64'(strobe_cnt - s0), 64'd0);
    endtask

    task automatic check_out(input string tag, input logic [7:0] exp);
        check({tag, "_out_cnt"}, 64'(out_q.size()), 64'd1);
        if (out_q.size() > 0) check({tag, "_out_byte"}, 64'(out_q[0]), 64'(exp));
        check({tag, "_stdout_hold"}, 64'(stdout), 64'(exp));
    endtask

    logic [15:0] pa, da;
    logic [7:0]  so;
    logic        se;
    int          wr1;
    int          guard;

    initial begin
        reset = 1'b1;
        en    = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_pc", 64'(prog_addr), 64'd0);
        check("rst_dp", 64'(data_addr), 64'd0);
        check("rst_stdout", 64'(stdout), 64'd0);
        check("rst_stdout_en", 64'(stdout_en), 64'd0);
        check("rst_strobes", 64'({prog_ren, data_ren, data_wen}), 64'd0);

        // "+++." : three increments then print
        start_prog("+++.");
        #1;
        check("t1_first_fetch", 64'({prog_ren, data_ren}), 64'b11);
        run_to_halt("t1");
        check("t1_wr_cnt", 64'(wr_val_q.size()), 64'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < wr_val_q.size()) begin
                check("t1_wr_addr", 64'(wr_addr_q[i]), 64'd0);
                check("t1_wr_val", 64'(wr_val_q[i]), 64'(i + 1));
            end
        end
        check_out("t1", 8'h03);
        check("t1_stdout_en_low", 64'(stdout_en), 64'd0);

        // "-." : decrement wraps
        start_prog("-.");
        run_to_halt("t2");
        check("t2_ram0", 64'(ram[0]), 64'hFFFF_FFFF);
        check_out("t2", 8'hFF);

        // Loop moving cell 0 into cell 1
        start_prog("++[>+<-]>.");
        run_to_halt("t3");
        check("t3_ram1", 64'(ram[1]), 64'd2);
        check("t3_ram0", 64'(ram[0]), 64'd0);
        wr1 = 0;
        foreach (wr_addr_q[i]) if (wr_addr_q[i] == 16'd1) wr1++;
        check("t3_body_twice", 64'(wr1), 64'd2);
        check_out("t3", 8'h02);

        // Nested skip
        start_prog("[+[+]]+.");
        run_to_halt("t4");
        check("t4_wr_cnt", 64'(wr_val_q.size()), 64'd1);
        check("t4_ram0", 64'(ram[0]), 64'd1);
        check_out("t4", 8'h01);

        // dp wraps below zero
        start_prog("<+.");
        run_to_halt("t5");
        check("t5_ram_ffff", 64'(ram[16'hFFFF]), 64'd1);
        check("t5_ram0", 64'(ram[0]), 64'd0);
        if (wr_addr_q.size() > 0) check("t5_wr_addr", 64'(wr_addr_q[0]), 64'hFFFF);
        check_out("t5", 8'h01);

        // Comment bytes
        start_prog("ab+.");
        run_to_halt("t6");
        check_out("t6", 8'h01);

        // Stall for 10 cycles mid-loop
        start_prog("++[>+<-]>.");
        repeat (9) @(negedge clk);
        pa = prog_addr;
        da = data_addr;
        so = stdout;
        se = stdout_en;
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("t7_stall_strobes", 64'({prog_ren, data_ren, data_wen}), 64'd0);
            @(negedge clk);
            check("t7_stall_frozen", {23'd0, prog_addr, data_addr, stdout, stdout_en},
                  {23'd0, pa, da, so, se});
        end
        en = 1'b1;
        run_to_halt("t7");
        check("t7_ram1", 64'(ram[1]), 64'd2);
        check("t7_ram0", 64'(ram[0]), 64'd0);
        check_out("t7", 8'h02);

        // Reset on the first loop-body write to cell 1: that write must be dropped
        start_prog("++[>+<-]>.");
        guard = 0;
        while (!(data_wen && data_addr == 16'd1) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("t8_found_write", 64'(guard < 200), 64'd1);
        reset = 1'b1;
        #1;
        check("t8_rst_wen", 64'(data_wen), 64'd0);
        @(negedge clk);
        check("t8_rst_pc", 64'(prog_addr), 64'd0);
        check("t8_rst_dp", 64'(data_addr), 64'd0);
        check("t8_rst_stdout", 64'({stdout, stdout_en}), 64'd0);
        check("t8_rst_ram1", 64'(ram[1]), 64'd0);
        out_q.delete();
        reset = 1'b0;
        #1;
        check("t8_restart_fetch", 64'({prog_ren, data_ren, prog_addr}), {46'd0, 2'b11, 16'd0});
        // RAM keeps cell 0 = 2, so the rerun counts from 4.
        run_to_halt("t8");
        check("t8_ram1", 64'(ram[1]), 64'd4);
        check("t8_ram0", 64'(ram[0]), 64'd0);
        check_out("t8", 8'h04);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
